// File: rtl/pong_match_controller.sv
// Pong match sequencer: owns the scores and decides when the ball runs, is
// re-centred and which way it is served; turns border misses into points.
module pong_match_controller #(
  parameter int unsigned WIN_SCORE   = 10,
  parameter int unsigned SERVE_TICKS = 64,
  parameter int unsigned POINT_TICKS = 32,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_run,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_RALLY     = 3'd2,
    S_POINT     = 3'd3,
    S_PAUSED    = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  localparam logic [3:0]       WIN       = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] SERVE_CNT = CNT_W'(SERVE_TICKS);
  localparam logic [CNT_W-1:0] POINT_CNT = CNT_W'(POINT_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] counter;

  assign state_o = state;

  // Match FSM; every output is a register updated alongside the state.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= S_IDLE;
      counter    <= '0;
      ball_run   <= 1'b0;
      ball_reset <= 1'b0;
      serve_dir  <= 1'b0;
      p1_score   <= 4'd0;
      p2_score   <= 4'd0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
    end else begin
      ball_reset <= 1'b0;
      case (state)
        S_IDLE, S_GAME_OVER: begin
          ball_run <= 1'b0;
          if (start) begin
            state      <= S_SERVE;
            p1_score   <= 4'd0;
            p2_score   <= 4'd0;
            counter    <= SERVE_CNT;
            ball_reset <= 1'b1;
            serve_dir  <= 1'b0;
            game_over  <= 1'b0;
          end
        end

        S_SERVE: begin
          ball_run <= 1'b0;
          if (tick) begin
            counter <= counter - CNT_ONE;
            if (counter == CNT_ONE) begin
              state    <= S_RALLY;
              ball_run <= 1'b1;
            end
          end
        end

        S_RALLY: begin
          if (miss_left || miss_right) begin
            // Simultaneous misses are a glitch: no point awarded.
            state    <= S_POINT;
            counter  <= POINT_CNT;
            ball_run <= 1'b0;
            if (miss_left && !miss_right) begin
              if (p2_score < WIN) p2_score <= p2_score + 4'd1;
              serve_dir <= 1'b0;
            end else if (miss_right && !miss_left) begin
              if (p1_score < WIN) p1_score <= p1_score + 4'd1;
              serve_dir <= 1'b1;
            end
          end else if (pause) begin
            state    <= S_PAUSED;
            ball_run <= 1'b0;
          end else begin
            ball_run <= 1'b1;
          end
        end

        S_PAUSED: begin
          if (!pause) begin
            state    <= S_RALLY;
            ball_run <= 1'b1;
          end else begin
            ball_run <= 1'b0;
          end
        end

        S_POINT: begin
          ball_run <= 1'b0;
          if (tick) begin
            counter <= counter - CNT_ONE;
            if (counter == CNT_ONE) begin
              if ((p1_score == WIN) || (p2_score == WIN)) begin
                state     <= S_GAME_OVER;
                game_over <= 1'b1;
                winner    <= (p2_score == WIN);
              end else begin
                state      <= S_SERVE;
                counter    <= SERVE_CNT;
                ball_reset <= 1'b1;
              end
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          ball_run  <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_match_controller.sv
// Self-checking bench for pong_match_controller: a directed vector table
// plus hand-written sequences for a full match and reset during POINT.
module tb_pong_match_controller;

  logic       clk = 1'b0;
  logic       reset, tick, start, pause, miss_left, miss_right;
  logic       ball_run, ball_reset, serve_dir, game_over, winner;
  logic [3:0] p1_score, p2_score;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  pong_match_controller dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .tick      (tick),
    .start     (start),
    .pause     (pause),
    .miss_left (miss_left),
    .miss_right(miss_right),
    .ball_run  (ball_run),
    .ball_reset(ball_reset),
    .serve_dir (serve_dir),
    .p1_score  (p1_score),
    .p2_score  (p2_score),
    .game_over (game_over),
    .winner    (winner),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned n;
    logic rst, tck, st, ps, ml, mr;
    logic [2:0] e_state;
    logic e_run, e_brst, e_dir;
    logic [3:0] e_p1, e_p2;
    logic e_go, e_win;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Hold the inputs for n clock edges, then settle just after the last edge.
  task automatic apply(input int unsigned n, input logic r, input logic t, input logic s,
                       input logic p, input logic l, input logic m);
    for (int k = 0; k < int'(n); k++) begin
      reset = r; tick = t; start = s; pause = p; miss_left = l; miss_right = m;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_all(input string tag, input logic [2:0] st, input logic run,
                            input logic brst, input logic dir, input logic [3:0] p1,
                            input logic [3:0] p2, input logic go, input logic win);
    check({tag, ".state"},      int'(state_o),    int'(st));
    check({tag, ".ball_run"},   int'(ball_run),   int'(run));
    check({tag, ".ball_reset"}, int'(ball_reset), int'(brst));
    check({tag, ".serve_dir"},  int'(serve_dir),  int'(dir));
    check({tag, ".p1_score"},   int'(p1_score),   int'(p1));
    check({tag, ".p2_score"},   int'(p2_score),   int'(p2));
    check({tag, ".game_over"},  int'(game_over),  int'(go));
    check({tag, ".winner"},     int'(winner),     int'(win));
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0; pause = 1'b0;
    miss_left = 1'b0; miss_right = 1'b0;

    //          n  rst tck st ps ml mr  state run brst dir p1 p2 go win
    vecs[0]  = '{2,  1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 4'd0, 4'd0, 0, 0};
    vecs[1]  = '{1,  0, 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 4'd0, 4'd0, 0, 0};
    vecs[2]  = '{1,  0, 0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 4'd0, 4'd0, 0, 0};
    vecs[3]  = '{1,  0, 0, 1, 0, 0, 0, 3'd1, 0, 1, 0, 4'd0, 4'd0, 0, 0};
    vecs[4]  = '{1,  0, 0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 4'd0, 4'd0, 0, 0};
    vecs[5]  = '{63, 0, 1, 0, 1, 0, 0, 3'd1, 0, 0, 0, 4'd0, 4'd0, 0, 0};
    vecs[6]  = '{1,  0, 1, 0, 0, 0, 0, 3'd2, 1, 0, 0, 4'd0, 4'd0, 0, 0};
    vecs[7]  = '{5,  0, 1, 0, 1, 0, 0, 3'd4, 0, 0, 0, 4'd0, 4'd0, 0, 0};
    vecs[8]  = '{1,  0, 0, 0, 0, 0, 0, 3'd2, 1, 0, 0, 4'd0, 4'd0, 0, 0};
    vecs[9]  = '{1,  0, 0, 0, 0, 0, 1, 3'd3, 0, 0, 1, 4'd1, 4'd0, 0, 0};
    vecs[10] = '{31, 0, 1, 0, 0, 0, 1, 3'd3, 0, 0, 1, 4'd1, 4'd0, 0, 0};
    vecs[11] = '{1,  0, 1, 0, 0, 0, 0, 3'd1, 0, 1, 1, 4'd1, 4'd0, 0, 0};
    vecs[12] = '{64, 0, 1, 0, 0, 0, 0, 3'd2, 1, 0, 1, 4'd1, 4'd0, 0, 0};
    vecs[13] = '{1,  0, 0, 0, 0, 1, 1, 3'd3, 0, 0, 1, 4'd1, 4'd0, 0, 0};
    vecs[14] = '{32, 0, 1, 0, 0, 0, 0, 3'd1, 0, 1, 1, 4'd1, 4'd0, 0, 0};
    vecs[15] = '{64, 0, 1, 0, 0, 0, 0, 3'd2, 1, 0, 1, 4'd1, 4'd0, 0, 0};
    vecs[16] = '{1,  0, 0, 0, 1, 1, 0, 3'd3, 0, 0, 0, 4'd1, 4'd1, 0, 0};
    vecs[17] = '{32, 0, 1, 0, 0, 0, 0, 3'd1, 0, 1, 0, 4'd1, 4'd1, 0, 0};

    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      apply(vecs[i].n, vecs[i].rst, vecs[i].tck, vecs[i].st, vecs[i].ps,
            vecs[i].ml, vecs[i].mr);
      expect_all($sformatf("row%0d", i), vecs[i].e_state, vecs[i].e_run, vecs[i].e_brst,
                 vecs[i].e_dir, vecs[i].e_p1, vecs[i].e_p2, vecs[i].e_go, vecs[i].e_win);
    end

    // Full match: player 2 wins with ten left-border misses.
    apply(1, 1, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      apply(64, 0, 1, 0, 0, 0, 0);
      check($sformatf("match%0d.rally", k), int'(state_o), 2);
      apply(1, 0, 0, 0, 0, 1, 0);
      check($sformatf("match%0d.p2", k), int'(p2_score), k);
      check($sformatf("match%0d.point", k), int'(state_o), 3);
      apply(32, 0, 1, 0, 0, 0, 0);
      if (k < 10) begin
        check($sformatf("match%0d.serve", k), int'(state_o), 1);
        check($sformatf("match%0d.recentre", k), int'(ball_reset), 1);
      end
    end
    expect_all("gameover", 3'd5, 0, 0, 0, 4'd0, 4'd10, 1, 1);
    apply(3, 0, 1, 0, 0, 1, 1);
    apply(2, 0, 1, 0, 0, 0, 1);
    apply(2, 0, 1, 0, 0, 1, 0);
    expect_all("gameover_hold", 3'd5, 0, 0, 0, 4'd0, 4'd10, 1, 1);
    apply(1, 0, 1, 1, 0, 0, 0);
    check("restart.state", int'(state_o), 1);
    check("restart.p1", int'(p1_score), 0);
    check("restart.p2", int'(p2_score), 0);
    check("restart.ball_reset", int'(ball_reset), 1);
    check("restart.game_over", int'(game_over), 0);
    apply(63, 0, 1, 0, 0, 0, 0);
    check("restart.serve_hold", int'(state_o), 1);
    apply(1, 0, 1, 0, 0, 0, 0);
    check("restart.rally", int'(state_o), 2);

    // Reset during POINT with tick in the same cycle.
    apply(1, 1, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 1, 0, 0, 0);
    apply(64, 0, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 1);
    apply(5, 0, 1, 0, 0, 0, 0);
    expect_all("pre_reset", 3'd3, 0, 0, 1, 4'd1, 4'd0, 0, 0);
    apply(1, 1, 1, 0, 0, 0, 0);
    expect_all("mid_point_reset", 3'd0, 0, 0, 0, 4'd0, 4'd0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
